mac_pipe: RTL and testbench

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_pipe_pkg.sv | 14 +
 rtl/mac_sat_add.sv | 28 ++
 rtl/mac_pipe.sv | 144 ++++++++++++++
 tb/tb_mac_pipe.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mac_pipe_pkg.sv
// Shared definitions for the two-stage multiply-accumulate pipeline.
package mac_pipe_pkg;

  // Default operand and accumulator widths.
  localparam int DATA_W_DEF = 4;
  localparam int ACC_W_DEF  = 8;

  // Per-sample operating mode.
  typedef enum logic {
    MODE_ADD = 1'b0,  // S = A*B + C, accumulator untouched
    MODE_ACC = 1'b1   // acc += A*B, S mirrors acc
  } mode_e;

endpackage : mac_pipe_pkg

// File: rtl/mac_sat_add.sv
// Unsigned saturating adder: the sum is formed one bit wider than the
// operands, and a carry into that extra bit clamps the result to all-ones.
module mac_sat_add #(
  parameter int ACC_W = mac_pipe_pkg::ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o
);

  logic [ACC_W:0] sum_wide_s;

  // Widened add followed by clamp-on-carry; the result never wraps.
  always_comb begin
    sum_wide_s = {1'b0, a_i} + {1'b0, b_i};
    sum_o      = {ACC_W{1'b0}};
    sat_o      = 1'b0;
    if (sum_wide_s[ACC_W]) begin
      sum_o = {ACC_W{1'b1}};
      sat_o = 1'b1;
    end else begin
      sum_o = sum_wide_s[ACC_W-1:0];
      sat_o = 1'b0;
    end
  end

endmodule : mac_sat_add

// File: rtl/mac_pipe.sv
// Two-stage multiply / add-or-accumulate pipeline with saturation.
// Stage 1 registers the product and its sample controls; stage 2 performs
// the saturating add and registers S, out_valid and the sticky ovf flag.
// ACC_W must be at least 2*DATA_W so the product fits the accumulator.
module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              mode,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [ACC_W-1:0]  C,
  output logic [ACC_W-1:0]  S,
  output logic              out_valid,
  output logic              ovf
);

  // Stage 1 state
  logic [2*DATA_W-1:0] p_d;
  logic [2*DATA_W-1:0] p_q;
  logic [ACC_W-1:0]    c_q;
  mode_e               mode_q;
  logic                clr_q;
  logic                vld_q;

  // Stage 2 state
  logic [ACC_W-1:0]    acc_d, acc_q;
  logic [ACC_W-1:0]    s_d, s_q;
  logic                out_valid_d, out_valid_q;
  logic                ovf_d, ovf_q;

  // Stage 2 datapath
  logic [ACC_W-1:0]    base_s;
  logic [ACC_W-1:0]    op_a_s;
  logic [ACC_W-1:0]    op_b_s;
  logic [ACC_W-1:0]    sum_s;
  logic                sat_s;

  // Full-width unsigned product of the incoming operands.
  always_comb begin
    p_d = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
  end

  // Stage 1 register: valid and acc_clr are captured every cycle (an idle
  // acc_clr still has to zero the accumulator); data only on a valid sample.
  always_ff @(posedge clk) begin
    if (clear) begin
      p_q    <= {(2*DATA_W){1'b0}};
      c_q    <= {ACC_W{1'b0}};
      mode_q <= MODE_ADD;
      clr_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      clr_q <= acc_clr;
      if (in_valid) begin
        p_q    <= p_d;
        c_q    <= C;
        mode_q <= mode_e'(mode);
      end
    end
  end

  // Operand selection: MODE_ADD adds C, MODE_ACC adds the (optionally
  // cleared) accumulator; the product is always the other operand.
  always_comb begin
    base_s = {ACC_W{1'b0}};
    op_a_s = {ACC_W{1'b0}};
    if (clr_q) begin
      base_s = {ACC_W{1'b0}};
    end else begin
      base_s = acc_q;
    end
    if (mode_q == MODE_ACC) begin
      op_a_s = base_s;
    end else begin
      op_a_s = c_q;
    end
    op_b_s = ACC_W'(p_q);
  end

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a_i   (op_a_s),
    .b_i   (op_b_s),
    .sum_o (sum_s),
    .sat_o (sat_s)
  );

  // Stage 2 next state: S/ovf/acc update only on a valid sample, except an
  // idle acc_clr which zeroes the accumulator without touching S.
  always_comb begin
    acc_d       = acc_q;
    s_d         = s_q;
    ovf_d       = ovf_q;
    out_valid_d = vld_q;
    if (vld_q) begin
      s_d = sum_s;
      if (mode_q == MODE_ACC) begin
        acc_d = sum_s;
      end else begin
        acc_d = acc_q;
      end
      if (sat_s) begin
        ovf_d = 1'b1;
      end else if ((mode_q == MODE_ACC) && clr_q) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end else if (clr_q) begin
      acc_d = {ACC_W{1'b0}};
    end else begin
      acc_d = acc_q;
    end
  end

  // Stage 2 register; clear flushes the result and the sticky flag.
  always_ff @(posedge clk) begin
    if (clear) begin
      acc_q       <= {ACC_W{1'b0}};
      s_q         <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign S         = s_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule : mac_pipe

// File: tb/tb_mac_pipe.sv
// Directed self-checking bench for mac_pipe (default widths 4/8).
// Inputs change 1 time unit after a rising edge; a sample driven there is
// captured at the next edge and its result is visible after the edge after.
module tb_mac_pipe;

  logic       clk;
  logic       clear;
  logic       in_valid;
  logic       mode;
  logic       acc_clr;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] c;
  logic [7:0] s;
  logic       out_valid;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  mac_pipe #(
    .DATA_W (4),
    .ACC_W  (8)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .A         (a),
    .B         (b),
    .C         (c),
    .S         (s),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic cl,
                       input logic [3:0] ai, input logic [3:0] bi,
                       input logic [7:0] ci);
    in_valid = v;
    mode     = m;
    acc_clr  = cl;
    a        = ai;
    b        = bi;
    c        = ci;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] es,
                         input logic ev, input logic eo);
    chk({tag, ".S"}, {24'd0, s}, {24'd0, es});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  logic [3:0] add_a [5] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15};
  logic [3:0] add_b [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic [7:0] add_c [5] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
  logic [7:0] add_s [5] = '{8'd4, 8'd15, 8'd32, 8'd55, 8'd84};

  initial begin
    clear = 1'b1;
    idle();
    #1;
    step();
    step();
    chk_out("reset", 8'd0, 1'b0, 1'b0);
    clear = 1'b0;

    // MODE_ADD back-to-back stream.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1'b1, 1'b0, 1'b0, add_a[i], add_b[i], add_c[i]);
      else idle();
      step();
      if (i == 0) chk("add.latency", {31'd0, out_valid}, 32'd0);
      else if (i <= 5) chk_out($sformatf("add%0d", i - 1), add_s[i-1], 1'b1, 1'b0);
      else chk_out("add.drain", 8'd84, 1'b0, 1'b0);
    end

    // MODE_ACC with acc_clr on the first sample: 3, 15, 42.
    drive(1'b1, 1'b1, 1'b1, 4'd3, 4'd1, 8'd0); step();
    drive(1'b1, 1'b1, 1'b0, 4'd6, 4'd2, 8'd0); step();
    chk_out("acc0", 8'd3, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd9, 4'd3, 8'd0); step();
    chk_out("acc1", 8'd15, 1'b1, 1'b0);
    idle(); step();
    chk_out("acc2", 8'd42, 1'b1, 1'b0);

    // Saturation: 225 then clamp to 255; MODE_ADD keeps ovf sticky.
    drive(1'b1, 1'b1, 1'b1, 4'd15, 4'd15, 8'd0); step();
    drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 8'd0); step();
    chk_out("sat0", 8'd225, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 8'd1); step();
    chk_out("sat1", 8'd255, 1'b1, 1'b1);
    // Non-saturating ACC sample with acc_clr releases the sticky flag.
    drive(1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 8'd0); step();
    chk_out("sat.add", 8'd7, 1'b1, 1'b1);
    idle(); step();
    chk_out("ovf.release", 8'd1, 1'b1, 1'b0);

    // Interleaving: ACC 2*2, ADD 1*1+10, ACC 3*3 -> 4, 11, 13.
    drive(1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 8'd0); step();
    drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 8'd10); step();
    chk_out("mix0", 8'd4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 8'd0); step();
    chk_out("mix1", 8'd11, 1'b1, 1'b0);
    idle(); step();
    chk_out("mix2", 8'd13, 1'b1, 1'b0);

    // Idle acc_clr zeroes acc without producing a result: next ACC 1*2 -> 2.
    drive(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 8'd0); step();
    drive(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 8'd0); step();
    chk_out("idleclr.hold", 8'd13, 1'b0, 1'b0);
    idle(); step();
    chk_out("idleclr.next", 8'd2, 1'b1, 1'b0);

    // Clear mid-flight: set ovf, launch 7*7, then clear flushes it.
    drive(1'b1, 1'b1, 1'b1, 4'd15, 4'd15, 8'd0); step();
    drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 8'd0); step();
    drive(1'b1, 1'b1, 1'b0, 4'd7, 4'd7, 8'd0); step();
    chk_out("pre.clear", 8'd255, 1'b1, 1'b1);
    idle();
    clear = 1'b1;
    step();
    chk_out("clear", 8'd0, 1'b0, 1'b0);
    clear = 1'b0;
    step();
    chk_out("clear.flush", 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd5, 4'd5, 8'd0); step();
    idle(); step();
    chk_out("post.clear", 8'd25, 1'b1, 1'b0);

    // Valid gap 1,0,1: output follows two cycles later, S holds in the gap.
    drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 8'd0); step();
    idle(); step();
    chk_out("gap0", 8'd1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 8'd0); step();
    chk_out("gap1", 8'd1, 1'b0, 1'b0);
    idle(); step();
    chk_out("gap2", 8'd4, 1'b1, 1'b0);
    step();
    chk_out("gap.end", 8'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mac_pipe
